bus_slave_select: RTL

//  Parametrised, registered bus slave-select unit; successor to the fixed 2-to-4 bus decoder.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_onehot_dec.sv | 16 +
 rtl/bus_slave_select.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM state encoding and default address/select widths
// used by the bus slave-select unit and the other bus blocks.
package bus_pkg;

  // Default widths shared across bus blocks
  localparam int BUS_ADDR_W = 8;
  localparam int BUS_SEL_W  = 2;

  // Slave-select FSM states; encodings are fixed so other blocks may decode them
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } bus_state_e;

endpackage : bus_pkg

// File: rtl/bus_onehot_dec.sv
// Combinational index -> one-hot decoder. Generic replacement for the old
// fixed 2-to-4 decoder; the caller registers the result.
module bus_onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  // Exactly one output bit set, at the position given by idx
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule : bus_onehot_dec

// File: rtl/bus_slave_select.sv
// Registered bus slave-select unit. Accepts one master request, decodes the top
// SEL_W address bits into a one-hot select held until the addressed slave acks,
// and pulses err for unmapped slaves or when the ack does not arrive in time.
module bus_slave_select
  import bus_pkg::*;
#(
  parameter int                    ADDR_W   = BUS_ADDR_W,
  parameter int                    SEL_W    = BUS_SEL_W,
  parameter logic [(1<<SEL_W)-1:0] SLV_MASK = '1,
  parameter int                    TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    req_ready,
  output logic [(1<<SEL_W)-1:0]   sel_out,
  input  logic [(1<<SEL_W)-1:0]   slv_ack,
  output logic                    done,
  output logic                    err
);

  localparam int N_SLV = 1 << SEL_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_e        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_SLV-1:0]  sel_q, sel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  req_idx;
  logic [N_SLV-1:0]  req_onehot;
  logic              addr_unused;

  // Only the top SEL_W address bits select a slave; the rest is don't-care here
  assign req_idx     = req_addr[ADDR_W-1 -: SEL_W];
  assign addr_unused = ^req_addr;

  bus_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .idx    (req_idx),
    .onehot (req_onehot)
  );

  // Next-state logic: accept in IDLE, hold select in ACTIVE until ack or timeout,
  // spend exactly one cycle in ERR to present the err pulse
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (req_valid) begin
          idx_d = req_idx;
          cnt_d = '0;
          if (SLV_MASK[req_idx]) begin
            state_d = ST_ACTIVE;
            sel_d   = req_onehot;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // Ack is checked first so an ack in the last allowed cycle still completes
        if (slv_ack[idx_q]) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          sel_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State, index, counter and output registers; reset clears the select at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign sel_out   = sel_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule : bus_slave_select
